ram_arbiter_2p: RTL and testbench



---
 rtl/ram_arbiter_2p.sv | 243 ++++++++++++++++++++++++
 tb/tb_ram_arbiter_2p.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_2p.sv
// ---------------------------------------------------------------------------
// ram_arbiter_2p
// Purpose : shares one single-port RAM between two requesters (A and B) on a
//           single clock. It gives round-robin fairness on ties and lets a
//           requester hold a locked burst of at most MAX_BURST grants. Read
//           data is returned only to the port that issued the read.
//
// Parameters
//   DWIDTH    : data width (must match the RAM data width)
//   AWIDTH    : address width
//   MAX_BURST : maximum consecutive grants to one locked requester (>= 1)
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   req_x             : port x requests an access; held until gnt_x
//   lock_x            : port x asks to keep ownership for following accesses
//   we_x              : 1 = write, 0 = read
//   adr_x, din_x      : port x address / write data
//   gnt_x             : port x access is driven onto the RAM this cycle
//   rvalid_x, rdata_x : port x read data, one cycle after a read grant
//   ram_ce/we/adr/din : RAM control, address and write data
//   ram_dout          : RAM read data (registered in the RAM)
//
// Optional build macro RAM_ARB_STATS_EN adds the saturating counters
//   gcnt_a, gcnt_b (grants per port) and conf_cnt (cycles with both requests).
// ---------------------------------------------------------------------------
module ram_arbiter_2p #(
   parameter int DWIDTH    = 8,
   parameter int AWIDTH    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic              lock_a,
   input  logic              we_a,
   input  logic [AWIDTH-1:0] adr_a,
   input  logic [DWIDTH-1:0] din_a,
   output logic              gnt_a,
   output logic              rvalid_a,
   output logic [DWIDTH-1:0] rdata_a,
   input  logic              req_b,
   input  logic              lock_b,
   input  logic              we_b,
   input  logic [AWIDTH-1:0] adr_b,
   input  logic [DWIDTH-1:0] din_b,
   output logic              gnt_b,
   output logic              rvalid_b,
   output logic [DWIDTH-1:0] rdata_b,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [AWIDTH-1:0] ram_adr,
   output logic [DWIDTH-1:0] ram_din,
   input  logic [DWIDTH-1:0] ram_dout
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [15:0]       gcnt_a,
   output logic [15:0]       gcnt_b,
   output logic [15:0]       conf_cnt
`endif
);

   // Counter wide enough to hold MAX_BURST itself, so cnt+1 never wraps.
   localparam int              CW      = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0]   MAX_B   = CW'(MAX_BURST);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);
   localparam logic            PORT_A  = 1'b0;
   localparam logic            PORT_B  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BURST_A = 2'd1,
      ST_BURST_B = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_burst_cnt;
   logic [CW-1:0]     w_burst_cnt_nxt;
   logic [CW-1:0]     w_cnt_inc;
   logic              r_last;
   logic              w_last_nxt;
   logic              r_rd_pend_a;
   logic              r_rd_pend_b;
   logic              w_gnt_a;
   logic              w_gnt_b;

   assign w_cnt_inc = r_burst_cnt + CNT_ONE;

   // Grant decision and next-state logic; no grant is ever issued during reset.
   always_comb begin
      w_gnt_a         = 1'b0;
      w_gnt_b         = 1'b0;
      w_state_nxt     = r_state;
      w_burst_cnt_nxt = r_burst_cnt;
      w_last_nxt      = r_last;

      if (rst) begin
         w_gnt_a = 1'b0;
         w_gnt_b = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_a && req_b) begin
                  // Tie goes to the port that was not granted last.
                  if (r_last == PORT_B) begin
                     w_gnt_a = 1'b1;
                  end else begin
                     w_gnt_b = 1'b1;
                  end
               end else if (req_a) begin
                  w_gnt_a = 1'b1;
               end else if (req_b) begin
                  w_gnt_b = 1'b1;
               end else begin
                  w_gnt_a = 1'b0;
               end
            end
            ST_BURST_A: begin
               if (req_a) begin
                  w_gnt_a = 1'b1;
               end else begin
                  w_gnt_a = 1'b0;
               end
            end
            ST_BURST_B: begin
               if (req_b) begin
                  w_gnt_b = 1'b1;
               end else begin
                  w_gnt_b = 1'b0;
               end
            end
            default: begin
               w_gnt_a = 1'b0;
               w_gnt_b = 1'b0;
            end
         endcase
      end

      if (w_gnt_a) begin
         w_last_nxt = PORT_A;
         if (lock_a && (w_cnt_inc < MAX_B)) begin
            w_state_nxt     = ST_BURST_A;
            w_burst_cnt_nxt = w_cnt_inc;
         end else begin
            w_state_nxt     = ST_IDLE;
            w_burst_cnt_nxt = {CW{1'b0}};
         end
      end else if (w_gnt_b) begin
         w_last_nxt = PORT_B;
         if (lock_b && (w_cnt_inc < MAX_B)) begin
            w_state_nxt     = ST_BURST_B;
            w_burst_cnt_nxt = w_cnt_inc;
         end else begin
            w_state_nxt     = ST_IDLE;
            w_burst_cnt_nxt = {CW{1'b0}};
         end
      end else begin
         // No grant: an owner that dropped its request loses the burst, and
         // this cycle is the single bubble before the other port can win.
         w_state_nxt     = ST_IDLE;
         w_burst_cnt_nxt = {CW{1'b0}};
      end
   end

   // RAM pin drive: the granted port's access, all zeros when idle.
   always_comb begin
      ram_ce  = 1'b0;
      ram_we  = 1'b0;
      ram_adr = {AWIDTH{1'b0}};
      ram_din = {DWIDTH{1'b0}};
      if (w_gnt_a) begin
         ram_ce  = 1'b1;
         ram_we  = we_a;
         ram_adr = adr_a;
         ram_din = din_a;
      end else if (w_gnt_b) begin
         ram_ce  = 1'b1;
         ram_we  = we_b;
         ram_adr = adr_b;
         ram_din = din_b;
      end else begin
         ram_ce  = 1'b0;
      end
   end

   // Arbiter state, burst counter, round-robin pointer and read tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_burst_cnt <= {CW{1'b0}};
         r_last      <= PORT_B;
         r_rd_pend_a <= 1'b0;
         r_rd_pend_b <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
         r_last      <= w_last_nxt;
         // The RAM registers its output, so read data arrives one cycle later.
         r_rd_pend_a <= w_gnt_a & ~we_a;
         r_rd_pend_b <= w_gnt_b & ~we_b;
      end
   end

   assign gnt_a    = w_gnt_a;
   assign gnt_b    = w_gnt_b;
   assign rvalid_a = r_rd_pend_a;
   assign rvalid_b = r_rd_pend_b;
   assign rdata_a  = r_rd_pend_a ? ram_dout : {DWIDTH{1'b0}};
   assign rdata_b  = r_rd_pend_b ? ram_dout : {DWIDTH{1'b0}};

`ifdef RAM_ARB_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

   logic [15:0] r_gcnt_a;
   logic [15:0] r_gcnt_b;
   logic [15:0] r_conf_cnt;

   // Saturating grant and simultaneous-request statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gcnt_a   <= 16'd0;
         r_gcnt_b   <= 16'd0;
         r_conf_cnt <= 16'd0;
      end else begin
         r_gcnt_a   <= w_gnt_a ? sat_inc16(r_gcnt_a) : r_gcnt_a;
         r_gcnt_b   <= w_gnt_b ? sat_inc16(r_gcnt_b) : r_gcnt_b;
         r_conf_cnt <= (req_a && req_b) ? sat_inc16(r_conf_cnt) : r_conf_cnt;
      end
   end

   assign gcnt_a   = r_gcnt_a;
   assign gcnt_b   = r_gcnt_b;
   assign conf_cnt = r_conf_cnt;
`endif

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter_2p
// Directed bench for ram_arbiter_2p with a behavioural RAM behind it. Every
// cycle the expected grants are given by the caller; read data expected from
// a shadow copy of what the bench wrote is queued on each read grant and
// compared when rvalid is due one cycle later. Counter checks are built when
// RAM_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_arbiter_2p;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_a, lock_a, we_a;
   logic [AW-1:0] adr_a;
   logic [DW-1:0] din_a;
   logic          gnt_a, rvalid_a;
   logic [DW-1:0] rdata_a;
   logic          req_b, lock_b, we_b;
   logic [AW-1:0] adr_b;
   logic [DW-1:0] din_b;
   logic          gnt_b, rvalid_b;
   logic [DW-1:0] rdata_b;
   logic          ram_ce, ram_we;
   logic [AW-1:0] ram_adr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = 8'h00;
`ifdef RAM_ARB_STATS_EN
   logic [15:0]   gcnt_a, gcnt_b, conf_cnt;
`endif

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] ram_mem [0:255];
   logic [DW-1:0] shadow  [0:255];
   logic [DW-1:0] sb_q [$];
   logic          exp_rv_a = 1'b0;
   logic          exp_rv_b = 1'b0;

   ram_arbiter_2p #(.DWIDTH(DW), .AWIDTH(AW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .lock_a(lock_a), .we_a(we_a), .adr_a(adr_a), .din_a(din_a),
      .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
      .req_b(req_b), .lock_b(lock_b), .we_b(we_b), .adr_b(adr_b), .din_b(din_b),
      .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
      .ram_dout(ram_dout)
`ifdef RAM_ARB_STATS_EN
      , .gcnt_a(gcnt_a), .gcnt_b(gcnt_b), .conf_cnt(conf_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with registered read data.
   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_we) ram_mem[ram_adr] <= ram_din;
         else        ram_dout <= ram_mem[ram_adr];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_a(input logic rq, input logic lk, input logic w,
                        input logic [AW-1:0] ad, input logic [DW-1:0] d);
      req_a = rq; lock_a = lk; we_a = w; adr_a = ad; din_a = d;
   endtask

   task automatic set_b(input logic rq, input logic lk, input logic w,
                        input logic [AW-1:0] ad, input logic [DW-1:0] d);
      req_b = rq; lock_b = lk; we_b = w; adr_b = ad; din_b = d;
   endtask

   // One clock cycle: check grants/RAM pins/read return at the falling edge,
   // update the scoreboard, then return 1 ns after the next rising edge.
   task automatic step(input logic ega, input logic egb, input string tag);
      logic [DW-1:0] exp_da;
      logic [DW-1:0] exp_db;
      exp_da = 8'h00;
      exp_db = 8'h00;
      @(negedge clk);
      check_val({tag, ".gnt_a"}, gnt_a, ega);
      check_val({tag, ".gnt_b"}, gnt_b, egb);
      check_val({tag, ".ram_ce"}, ram_ce, ega | egb);
      if (ega) begin
         check_val({tag, ".ram_we"}, ram_we, we_a);
         check_val({tag, ".ram_adr"}, ram_adr, adr_a);
         check_val({tag, ".ram_din"}, ram_din, din_a);
      end else if (egb) begin
         check_val({tag, ".ram_we"}, ram_we, we_b);
         check_val({tag, ".ram_adr"}, ram_adr, adr_b);
         check_val({tag, ".ram_din"}, ram_din, din_b);
      end else begin
         check_val({tag, ".ram_idle"}, {ram_we, ram_adr, ram_din}, 17'd0);
      end
      if (exp_rv_a || exp_rv_b) begin
         if (sb_q.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'd0, 32'd1);
         end else if (exp_rv_a) begin
            exp_da = sb_q.pop_front();
         end else begin
            exp_db = sb_q.pop_front();
         end
      end
      check_val({tag, ".rvalid_a"}, rvalid_a, exp_rv_a);
      check_val({tag, ".rvalid_b"}, rvalid_b, exp_rv_b);
      check_val({tag, ".rdata_a"}, rdata_a, exp_da);
      check_val({tag, ".rdata_b"}, rdata_b, exp_db);
      exp_rv_a = ega & ~we_a;
      exp_rv_b = egb & ~we_b;
      if (ega && !we_a) sb_q.push_back(shadow[adr_a]);
      if (ega && we_a)  shadow[adr_a] = din_a;
      if (egb && !we_b) sb_q.push_back(shadow[adr_b]);
      if (egb && we_b)  shadow[adr_b] = din_b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      // Requests held high during reset must not produce grants.
      set_a(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      set_b(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      step(1'b0, 1'b0, "rst0");
      step(1'b0, 1'b0, "rst1");
      rst = 1'b0;
      set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, "idle");

      // Write by A, read back by B with one-cycle latency.
      set_a(1'b1, 1'b0, 1'b1, 8'h10, 8'hAA);
      step(1'b1, 1'b0, "t1_wa");
      set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_b(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
      step(1'b0, 1'b1, "t1_rb");
      set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, "t1_rv");

      // More data for later reads; last granted ends as B.
      set_a(1'b1, 1'b0, 1'b1, 8'h20, 8'h5C);
      step(1'b1, 1'b0, "pre_a");
      set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_b(1'b1, 1'b0, 1'b1, 8'h30, 8'hC3);
      step(1'b0, 1'b1, "pre_b");

      // Both requesting, unlocked: strict alternation starting with A.
      set_a(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      set_b(1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step(i % 2 == 0, i % 2 == 1, "t2_rr");
      end
      set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, "t2_end");

      // Locked A burst: 4 grants, then B, then A again.
      set_a(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
      set_b(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      for (int i = 0; i < MB; i++) begin
         step(1'b1, 1'b0, "t3_burst");
      end
      step(1'b0, 1'b1, "t3_b");
      step(1'b1, 1'b0, "t3_a_again");

      // A is in BURST_A and drops its request: one bubble, then B.
      set_a(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      step(1'b0, 1'b0, "t4_bubble");
      step(1'b0, 1'b1, "t4_b");
      set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, "t4_end");

      // Reset with an A read in flight drops rvalid; afterwards A wins a tie.
      set_a(1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
      step(1'b1, 1'b0, "t5_ra");
      rst = 1'b1;
      sb_q.delete();
      exp_rv_a = 1'b0;
      exp_rv_b = 1'b0;
      set_b(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      step(1'b0, 1'b0, "t5_rst");
      rst = 1'b0;
      step(1'b1, 1'b0, "t5_tie");
      set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, "t5_end");

`ifdef RAM_ARB_STATS_EN
      rst = 1'b1;
      sb_q.delete();
      exp_rv_a = 1'b0;
      exp_rv_b = 1'b0;
      step(1'b0, 1'b0, "t6_rst");
      rst = 1'b0;
      check_val("t6_zero", {gcnt_a, gcnt_b, conf_cnt}, 48'd0);
      set_a(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
      set_b(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      step(1'b1, 1'b0, "t6_c0");
      step(1'b0, 1'b1, "t6_c1");
      set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "t6_a");
      set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_b(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, "t6_b");
      set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, "t6_end");
      check_val("t6_gcnt_a", gcnt_a, 16'd5);
      check_val("t6_gcnt_b", gcnt_b, 16'd3);
      check_val("t6_conf", conf_cnt, 16'd2);
      force dut.r_gcnt_a = 16'hFFFF;
      #1;
      release dut.r_gcnt_a;
      set_a(1'b1, 1'b0, 1'b1, 8'h40, 8'h01);
      step(1'b1, 1'b0, "t6_sat");
      set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check_val("t6_gcnt_sat", gcnt_a, 16'hFFFF);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
